// File: rtl/disc_reader_pkg.sv
// Shared encodings for the flux acquisition engine: start modes, byte codes
// and controller states.
package disc_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACQ  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_IMMEDIATE = 2'b00;
    localparam logic [1:0] MODE_INDEX     = 2'b01;
    localparam logic [1:0] MODE_TRKMARK   = 2'b10;

    localparam logic [6:0] CARRY_CODE = 7'h00;
    localparam logic [6:0] TIMER_MAX  = 7'd127;

    // Mode 11 is an alias of immediate start.
    function automatic logic mode_is_immediate(input logic [1:0] mode);
        return (mode == MODE_IMMEDIATE) || (mode == 2'b11);
    endfunction

endpackage

// File: rtl/disc_input_sync.sv
// Synchroniser for one asynchronous drive input followed by a rising-edge
// detector; o_rise is a single-clock pulse per low-to-high transition.
module disc_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/disc_reader.sv
// Flux acquisition engine: times flux intervals in clken ticks and streams
// {index_seen, interval} bytes into acquisition memory.
module disc_reader
    import disc_reader_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int IDXCNT_WIDTH = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_clken,
    input  logic                    i_rddata,
    input  logic                    i_index,
    input  logic                    i_trkmark,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [1:0]              i_start_mode,
    input  logic [IDXCNT_WIDTH-1:0] i_stop_index,
    input  logic                    i_mfull,
    output logic [7:0]              o_mdat,
    output logic                    o_mwrite,
    output logic                    o_waiting,
    output logic                    o_running,
    output logic                    o_full_stop
);

    logic w_rd_rise;
    logic w_idx_rise;
    logic w_trk_rise;

    disc_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_rddata),
        .o_rise  (w_rd_rise)
    );

    disc_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_idx (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_index),
        .o_rise  (w_idx_rise)
    );

    disc_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trk (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_trkmark),
        .o_rise  (w_trk_rise)
    );

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [6:0]              r_timer;
    logic [IDXCNT_WIDTH-1:0] r_idxcnt;
    logic                    r_idx_flag;
    logic                    r_flux_pend;
    logic                    r_idx_pend;
    logic [7:0]              r_mdat;
    logic                    r_mwrite;
    logic                    r_full_stop;

    state_t                  w_state_nxt;
    logic [6:0]              w_timer_nxt;
    logic [IDXCNT_WIDTH-1:0] w_idxcnt_nxt;
    logic                    w_idx_flag_nxt;
    logic                    w_emit;
    logic [7:0]              w_emit_dat;
    logic                    w_want;
    logic                    w_start_ok;
    logic                    w_full_set;
    logic                    w_consume;

    logic [6:0]              w_n;
    logic                    w_flag;
    logic [IDXCNT_WIDTH-1:0] w_idxcnt_inc;
    logic                    w_stop;

    assign w_n          = r_timer + 7'd1;
    assign w_flag       = r_idx_flag | r_idx_pend;
    assign w_idxcnt_inc = r_idxcnt + {{(IDXCNT_WIDTH-1){1'b0}}, 1'b1};
    assign w_stop       = r_idx_pend && (i_stop_index != '0) && (w_idxcnt_inc == i_stop_index);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_idxcnt_nxt   = r_idxcnt;
        w_idx_flag_nxt = r_idx_flag;
        w_emit         = 1'b0;
        w_emit_dat     = 8'h00;
        w_want         = 1'b0;
        w_start_ok     = 1'b0;
        w_full_set     = 1'b0;
        w_consume      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_start_ok     = 1'b1;
                    w_timer_nxt    = '0;
                    w_idxcnt_nxt   = '0;
                    w_idx_flag_nxt = 1'b0;
                    w_state_nxt    = mode_is_immediate(i_start_mode) ? ST_ACQ : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if ((r_mode == MODE_INDEX && w_idx_rise) ||
                             (r_mode == MODE_TRKMARK && w_trk_rise)) begin
                    // Trigger edge only starts the run; it is not counted.
                    w_timer_nxt    = '0;
                    w_idxcnt_nxt   = '0;
                    w_idx_flag_nxt = 1'b0;
                    w_state_nxt    = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_clken) begin
                    w_consume = 1'b1;
                    if (r_idx_pend) w_idxcnt_nxt = w_idxcnt_inc;
                    if (w_stop) begin
                        w_want     = 1'b1;
                        w_emit_dat = {1'b1, w_n};
                    end else if (r_flux_pend) begin
                        w_want     = 1'b1;
                        w_emit_dat = {w_flag, w_n};
                    end else if (w_n == TIMER_MAX) begin
                        w_want     = 1'b1;
                        w_emit_dat = {w_flag, CARRY_CODE};
                    end else begin
                        w_timer_nxt    = w_n;
                        w_idx_flag_nxt = w_flag;
                    end
                    if (w_want) begin
                        if (i_mfull) begin
                            w_full_set  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_emit         = 1'b1;
                            w_timer_nxt    = '0;
                            w_idx_flag_nxt = 1'b0;
                            if (w_stop) w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mode      <= MODE_IMMEDIATE;
            r_timer     <= '0;
            r_idxcnt    <= '0;
            r_idx_flag  <= 1'b0;
            r_flux_pend <= 1'b0;
            r_idx_pend  <= 1'b0;
            r_mdat      <= 8'h00;
            r_mwrite    <= 1'b0;
            r_full_stop <= 1'b0;
        end else begin
            r_timer    <= w_timer_nxt;
            r_idxcnt   <= w_idxcnt_nxt;
            r_idx_flag <= w_idx_flag_nxt;
            r_mwrite   <= w_emit;
            if (w_emit) r_mdat <= w_emit_dat;
            if (w_start_ok) begin
                r_mode      <= i_start_mode;
                r_full_stop <= 1'b0;
            end else if (w_full_set) begin
                r_full_stop <= 1'b1;
            end
            // Edges are held until the next clken tick; outside ACQ they are dropped.
            if (r_state == ST_ACQ) begin
                r_flux_pend <= (r_flux_pend & ~w_consume) | w_rd_rise;
                r_idx_pend  <= (r_idx_pend & ~w_consume) | w_idx_rise;
            end else begin
                r_flux_pend <= 1'b0;
                r_idx_pend  <= 1'b0;
            end
        end
    end

    assign o_mdat      = r_mdat;
    assign o_mwrite    = r_mwrite;
    assign o_waiting   = (r_state == ST_WAIT);
    assign o_running   = (r_state == ST_ACQ);
    assign o_full_stop = r_full_stop;

endmodule

// File: tb/tb_disc_reader.sv
// Directed bench for disc_reader: bytes are captured on the falling edge and
// compared against hand-derived intervals and cycle positions.
module tb_disc_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b1;
    logic       rddata = 1'b0;
    logic       index = 1'b0;
    logic       trkmark = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mfull = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] stop_index = 8'd0;
    logic [7:0] mdat;
    logic       mwrite, waiting, running, full_stop;

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] wq[$];
    int         wc[$];

    disc_reader #(.SYNC_STAGES(2), .IDXCNT_WIDTH(8)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_clken      (clken),
        .i_rddata     (rddata),
        .i_index      (index),
        .i_trkmark    (trkmark),
        .i_start      (start),
        .i_abort      (abort),
        .i_start_mode (mode),
        .i_stop_index (stop_index),
        .i_mfull      (mfull),
        .o_mdat       (mdat),
        .o_mwrite     (mwrite),
        .o_waiting    (waiting),
        .o_running    (running),
        .o_full_stop  (full_stop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mwrite === 1'b1) begin
        wq.push_back(mdat);
        wc.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_total++; if (mwrite !== 1'b0) $display("FAIL reset_mwrite got %0b want 0", mwrite); else n_pass++;
        n_total++; if (mdat !== 8'h00) $display("FAIL reset_mdat got %02h want 00", mdat); else n_pass++;
        n_total++; if (waiting !== 1'b0) $display("FAIL reset_waiting got %0b want 0", waiting); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL reset_running got %0b want 0", running); else n_pass++;
        n_total++; if (full_stop !== 1'b0) $display("FAIL reset_full_stop got %0b want 0", full_stop); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_periodic();
        int s, k0;
        wq.delete(); wc.delete();
        mode = 2'b00; start = 1'b1; step(); start = 1'b0; s = cyc;
        n_total++; if (running !== 1'b1) $display("FAIL periodic_running got %0b want 1", running); else n_pass++;
        repeat (4) step();
        k0 = cyc + 1;
        for (int p = 0; p < 4; p++) begin
            rddata = 1'b1; step(); rddata = 1'b0; repeat (9) step();
        end
        n_total++; if (wq.size() !== 4) $display("FAIL periodic_count got %0d want 4", wq.size()); else n_pass++;
        n_total++; if (wc[0] !== k0 + 3) $display("FAIL periodic_latency got %0d want %0d", wc[0], k0 + 3); else n_pass++;
        n_total++; if (wq[0] !== 8'h08) $display("FAIL periodic_first got %02h want 08", wq[0]); else n_pass++;
        for (int j = 1; j < 4; j++) begin
            n_total++; if (wq[j] !== 8'h0A) $display("FAIL periodic_byte%0d got %02h want 0a", j, wq[j]); else n_pass++;
        end
        n_total++; if (wc[1] !== s + 18) $display("FAIL periodic_spacing got %0d want %0d", wc[1], s + 18); else n_pass++;
        abort = 1'b1; step(); abort = 1'b0;
        n_total++; if (running !== 1'b0) $display("FAIL periodic_abort got %0b want 0", running); else n_pass++;
    endtask

    task automatic test_clken();
        wq.delete(); wc.delete();
        clken = 1'b0; mode = 2'b00; start = 1'b1; step(); start = 1'b0;
        rddata = 1'b1; step(); rddata = 1'b0; repeat (6) step();
        n_total++; if (wq.size() !== 0) $display("FAIL clken_hold got %0d writes want 0", wq.size()); else n_pass++;
        clken = 1'b1; step(); clken = 1'b0; repeat (3) step();
        n_total++; if (wq.size() !== 1) $display("FAIL clken_count got %0d want 1", wq.size()); else n_pass++;
        n_total++; if (wq[0] !== 8'h01) $display("FAIL clken_byte got %02h want 01", wq[0]); else n_pass++;
        clken = 1'b1; abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_carry();
        int s;
        wq.delete(); wc.delete();
        mode = 2'b00; start = 1'b1; step(); start = 1'b0; s = cyc;
        repeat (296) step();
        rddata = 1'b1; step(); rddata = 1'b0; repeat (6) step();
        n_total++; if (wq.size() !== 3) $display("FAIL carry_count got %0d want 3", wq.size()); else n_pass++;
        n_total++; if (wq[0] !== 8'h00) $display("FAIL carry_b0 got %02h want 00", wq[0]); else n_pass++;
        n_total++; if (wq[1] !== 8'h00) $display("FAIL carry_b1 got %02h want 00", wq[1]); else n_pass++;
        n_total++; if (wq[2] !== 8'h2E) $display("FAIL carry_b2 got %02h want 2e", wq[2]); else n_pass++;
        n_total++; if (wc[0] !== s + 127) $display("FAIL carry_c0 got %0d want %0d", wc[0], s + 127); else n_pass++;
        n_total++; if (wc[2] !== s + 300) $display("FAIL carry_c2 got %0d want %0d", wc[2], s + 300); else n_pass++;
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_index_stop();
        int base;
        wq.delete(); wc.delete();
        mode = 2'b01; stop_index = 8'd2; start = 1'b1; step(); start = 1'b0;
        n_total++; if (waiting !== 1'b1) $display("FAIL index_waiting got %0b want 1", waiting); else n_pass++;
        base = cyc;
        for (int i = 0; i < 2200; i++) begin
            rddata = (i % 50 == 25);
            index  = (i == 100 || i == 1100 || i == 2100);
            step();
        end
        rddata = 1'b0; index = 1'b0;
        n_total++; if (wq.size() !== 41) $display("FAIL index_count got %0d want 41", wq.size()); else n_pass++;
        n_total++; if (wc[0] !== base + 129) $display("FAIL index_first_cyc got %0d want %0d", wc[0], base + 129); else n_pass++;
        n_total++; if (wq[0] !== 8'h1A) $display("FAIL index_first got %02h want 1a", wq[0]); else n_pass++;
        n_total++; if (wq[19] !== 8'h32) $display("FAIL index_before got %02h want 32", wq[19]); else n_pass++;
        n_total++; if (wq[20] !== 8'hB2) $display("FAIL index_flagged got %02h want b2", wq[20]); else n_pass++;
        n_total++; if (wq[21] !== 8'h32) $display("FAIL index_after got %02h want 32", wq[21]); else n_pass++;
        n_total++; if (wq[40] !== 8'h99) $display("FAIL index_flush got %02h want 99", wq[40]); else n_pass++;
        n_total++; if (wc[40] !== base + 2104) $display("FAIL index_flush_cyc got %0d want %0d", wc[40], base + 2104); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL index_stopped got %0b want 0", running); else n_pass++;
        stop_index = 8'd0;
    endtask

    task automatic test_mfull();
        wq.delete(); wc.delete();
        mode = 2'b00; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            rddata = (i % 10 == 5);
            step();
            if (wq.size() >= 4) mfull = 1'b1;
        end
        rddata = 1'b0;
        n_total++; if (wq.size() !== 4) $display("FAIL mfull_count got %0d want 4", wq.size()); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL mfull_running got %0b want 0", running); else n_pass++;
        n_total++; if (full_stop !== 1'b1) $display("FAIL mfull_flag got %0b want 1", full_stop); else n_pass++;
        mfull = 1'b0; repeat (5) step();
        n_total++; if (full_stop !== 1'b1) $display("FAIL mfull_sticky got %0b want 1", full_stop); else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        n_total++; if (full_stop !== 1'b0) $display("FAIL mfull_clear got %0b want 0", full_stop); else n_pass++;
        n_total++; if (running !== 1'b1) $display("FAIL mfull_restart got %0b want 1", running); else n_pass++;
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_abort_trkmark();
        wq.delete(); wc.delete();
        mode = 2'b10; start = 1'b1; step(); start = 1'b0;
        n_total++; if (waiting !== 1'b1) $display("FAIL abort_wait got %0b want 1", waiting); else n_pass++;
        repeat (3) step();
        abort = 1'b1; step(); abort = 1'b0;
        n_total++; if (waiting !== 1'b0) $display("FAIL abort_drop got %0b want 0", waiting); else n_pass++;
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        n_total++; if (waiting !== 1'b0) $display("FAIL abort_wins got %0b want 0", waiting); else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        n_total++; if (waiting !== 1'b1) $display("FAIL trk_rearm got %0b want 1", waiting); else n_pass++;
        trkmark = 1'b1; step(); trkmark = 1'b0; step();
        n_total++; if (running !== 1'b0) $display("FAIL trk_early got %0b want 0", running); else n_pass++;
        step();
        n_total++; if (running !== 1'b1) $display("FAIL trk_enter got %0b want 1", running); else n_pass++;
        repeat (5) step();
        abort = 1'b1; step(); abort = 1'b0;
        n_total++; if (wq.size() !== 0) $display("FAIL abort_writes got %0d want 0", wq.size()); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        mode = 2'b00; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rddata = (i % 10 == 3); step();
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rddata = (i % 4 == 1); step();
            n_total++; if (mwrite !== 1'b0) $display("FAIL rst_mwrite%0d got %0b want 0", i, mwrite); else n_pass++;
        end
        rst = 1'b0; rddata = 1'b0; step();
        n_total++; if (running !== 1'b0) $display("FAIL rst_running got %0b want 0", running); else n_pass++;
        n_total++; if (waiting !== 1'b0) $display("FAIL rst_waiting got %0b want 0", waiting); else n_pass++;
        n_total++; if (full_stop !== 1'b0) $display("FAIL rst_full_stop got %0b want 0", full_stop); else n_pass++;
        n_total++; if (mdat !== 8'h00) $display("FAIL rst_mdat got %02h want 00", mdat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_clken();
        test_carry();
        test_index_stop();
        test_mfull();
        test_abort_trkmark();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout after %0d cycles", cyc);
        $fatal(1);
    end

endmodule

// File: doc/disc_reader.md
Name: disc_reader

Overview:
Flux acquisition engine: the read-side counterpart of the disc writer.
- Times the interval between flux transitions on the drive's read-data line, in clken ticks.
- Packs each interval, plus an index-seen flag, into one byte.
- Streams the bytes into acquisition RAM with a write/post-increment strobe.
- Sits between the drive input pins and the acquisition memory controller; start/stop are driven from the register file.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for the asynchronous drive inputs (minimum 2).
- IDXCNT_WIDTH, 8, width of stop_index and of the internal index counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  sample-clock enable; one timing tick per clock with clken=1.
- rddata  in  1  async drive read data; rising edge = flux transition.
- index  in  1  async index pulse, active high.
- trkmark  in  1  async track-mark detector hit, active high.
- start  in  1  one-clock start pulse.
- abort  in  1  one-clock stop request.
- start_mode  in  2  00=immediate, 01=on index, 10=on trkmark, 11=immediate.
- stop_index  in  IDXCNT_WIDTH  stop after this many index edges; 0=no index stop.
- mfull  in  1  acquisition memory full.
- mdat  out  8  byte to memory.
- mwrite  out  1  one-clock strobe: memory writes mdat, then increments its address.
- waiting  out  1  armed, waiting for start condition.
- running  out  1  acquiring.
- full_stop  out  1  last run ended on mfull; sticky until the next start.

Behaviour:
- Reset: all outputs 0; state IDLE; timer, index counter and pending flags cleared. Same effect when reset is asserted mid-run; no partial byte is written.
- Inputs: each async input passes through SYNC_STAGES flops, then a previous-value flop. An edge is synced & ~prev, detected on every clock.
- Edges are latched into pending flags, which are consumed on the next clken tick, so no edge is lost when clken < 1.
- States: IDLE, WAIT, ACQ.
  - IDLE: start enters WAIT (or ACQ directly for modes 00/11) and clears full_stop. start is ignored in WAIT and ACQ.
  - WAIT: waiting=1. Enters ACQ on the first index edge (mode 01) or trkmark edge (mode 10). The triggering edge is neither counted nor flagged.
  - ACQ: running=1. On entry, timer=0, index count=0, idx_flag=0.
- Per clken tick in ACQ, with n = timer+1 (range 1..127):
  - Flux edge pending: emit {idx_flag, n[6:0]}; timer <= 0.
  - No edge and n==127: emit carry byte {idx_flag, 7'h00}, meaning 127 ticks with no transition; timer <= 0.
  - Otherwise: timer <= n.
  - A flux edge takes priority over the carry byte.
  - Decode rule: interval = 127 × carries + final n.
- Index edge in ACQ sets idx_flag. The flag goes out in bit 7 of the next emitted byte, which may be the same tick, and is cleared on emit. The index counter increments on the same edge.
- Index stop: stop_index != 0 and the counter reaches stop_index → emit a flush byte {1, n} that tick, then go to IDLE.
- Emit: mdat and mwrite are registered. mwrite is high for exactly one clock per byte, and mdat is valid while mwrite=1.
- Latency (clken=1, SYNC_STAGES=2): rddata first sampled high at clock edge k → mwrite=1 in the cycle after edge k+3.
- mfull=1 on a tick that would emit: no write; go to IDLE; full_stop=1.
- abort (WAIT or ACQ): IDLE on the next clock, with no write that cycle. abort and start in the same clock: abort wins.
- IDLE: timer frozen and pending flags cleared; edges are ignored.

Decomposition:
- Shared package: start_mode encodings (MODE_IMMEDIATE, MODE_INDEX, MODE_TRKMARK), CARRY_CODE=7'h00, TIMER_MAX=127, state encodings.
- One natural sub-module: disc_input_sync (SYNC_STAGES synchroniser + rising-edge detector), instantiated three times.

Test Plan:
- Reset held for 10 clocks mid-ACQ → mwrite=0 throughout; running=0, waiting=0, full_stop=0 on the clock after reset.
- Mode 00, clken=1, rddata pulses 10 clocks apart → bytes 0x0A repeating; first byte's mwrite 3 clocks after the first rddata sample.
- Mode 00, single transition 300 ticks after start → 0x00, 0x00, then 0x2E (127+127+46).
- Mode 01, stop_index=2, index pulses 1000 clocks apart, rddata every 50 clocks → nothing before the first index. The first byte after the second index has bit 7 set. A flush byte {1,n} follows the third index, then running=0.
- Mode 00, mfull asserted after 4 bytes → exactly 4 mwrite pulses; running=0; full_stop=1 until the next start.
- Mode 10, abort in WAIT, then start with trkmark → waiting drops next clock with no writes; the second run enters ACQ on the trkmark edge.
